// File: rtl/seg_scan_display_if.sv
// Bus bundle for the seven-segment scan driver: game-logic side (master)
// supplies the value/load/format controls, the driver (slave) returns pins
// and status.
interface seg_scan_display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int VAL_W      = 14
);
  logic [VAL_W-1:0]      i_value;
  logic                  i_load;
  logic                  i_blank_lz;
  logic [NUM_DIGITS-1:0] i_dp;
  logic [7:0]            o_seg;
  logic [NUM_DIGITS-1:0] o_an;
  logic                  o_busy;
  logic                  o_ovf;
  logic [1:0]            o_dbg_state;

  // Handshake: i_load is a single-cycle strobe that is accepted only while
  // o_busy=0; a strobe seen while o_busy=1 is dropped, never queued. o_busy
  // rises the cycle after an accepted strobe and falls on the cycle the new
  // value becomes visible to the scan logic.
  modport master (
    output i_value, i_load, i_blank_lz, i_dp,
    input  o_seg, o_an, o_busy, o_ovf, o_dbg_state
  );

  modport slave (
    input  i_value, i_load, i_blank_lz, i_dp,
    output o_seg, o_an, o_busy, o_ovf, o_dbg_state
  );
endinterface

// File: rtl/seg_scan_display.sv
// Multi-digit seven-segment scan driver. Binary input is converted to BCD by
// a sequential double-dabble FSM, then digits are time-multiplexed on the
// shared segment bus with leading-zero blanking, decimal points and an
// overflow dash pattern. Outputs are registered.
module seg_scan_display #(
  parameter int NUM_DIGITS = 4,
  parameter int VAL_W      = 14,
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic              i_clk,
  input logic              i_rst_n,
  seg_scan_display_if.slave bus
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(VAL_W + 1);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [7:0]            SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? '1 : '0;

  // Largest value that fits in NUM_DIGITS decimal digits.
  function automatic logic [31:0] max_decimal(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) p = p * 32'd10;
    return p - 32'd1;
  endfunction
  localparam logic [31:0] MAX_VAL = max_decimal(NUM_DIGITS);

  // Active-high gfedcba glyph for a BCD digit.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  logic [1:0]            state_q, state_d;
  logic [VAL_W-1:0]      sh_q, sh_d;
  logic [BW-1:0]         work_q, work_d;
  logic [BW-1:0]         adj;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic [BW-1:0]         disp_q, disp_d;
  logic                  ovf_q, ovf_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [DW-1:0]         dig_q, dig_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [7:0]            seg_act;
  logic [NUM_DIGITS-1:0] an_act;
  int                    hi_idx;

  // Conversion FSM: capture on load, VAL_W add-3/shift steps, then commit.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    adj        = work_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (work_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
    end
    case (state_q)
      ST_IDLE: begin
        if (bus.i_load) begin
          sh_d       = bus.i_value;
          work_d     = '0;
          cnt_d      = '0;
          ovf_pend_d = ({{(32-VAL_W){1'b0}}, bus.i_value} > MAX_VAL);
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Carry out of the top nibble falls off the end intentionally.
        work_d = {adj[BW-2:0], sh_q[VAL_W-1]};
        sh_d   = sh_q << 1;
        if (cnt_q == CW'(VAL_W - 1)) state_d = ST_COMMIT;
        else                         cnt_d   = cnt_q + 1'b1;
      end
      ST_COMMIT: begin
        disp_d  = work_q;
        ovf_d   = ovf_pend_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Free-running scan: prescaler paces the digit index independently of the FSM.
  always_comb begin
    presc_d = presc_q + 1'b1;
    dig_d   = dig_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      dig_d   = (dig_q == DW'(NUM_DIGITS - 1)) ? '0 : dig_q + 1'b1;
    end
  end

  // Segment/anode pattern for the digit currently selected by the scan index.
  always_comb begin
    hi_idx    = 0;
    cur_nib   = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_act    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (disp_q[4*k +: 4] != 4'd0) hi_idx = k;
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_q == DW'(k)) begin
        cur_nib   = disp_q[4*k +: 4];
        cur_dp    = bus.i_dp[k];
        cur_blank = bus.i_blank_lz && !ovf_q && (k > hi_idx);
        an_act[k] = 1'b1;
      end
    end
    if (ovf_q)          seg_act = {cur_dp, 7'h40};
    else if (cur_blank) seg_act = {cur_dp, 7'h00};
    else                seg_act = {cur_dp, glyph(cur_nib)};
    seg_d = ACTIVE_LOW ? ~seg_act : seg_act;
    an_d  = ACTIVE_LOW ? ~an_act  : an_act;
  end

  // State registers; async reset blanks the display and aborts any conversion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      sh_q       <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      presc_q    <= '0;
      dig_q      <= '0;
      seg_q      <= SEG_OFF;
      an_q       <= AN_OFF;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      presc_q    <= presc_d;
      dig_q      <= dig_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign bus.o_seg       = seg_q;
  assign bus.o_an        = an_q;
  assign bus.o_busy      = (state_q != ST_IDLE);
  assign bus.o_ovf       = ovf_q;
  assign bus.o_dbg_state = state_q;
endmodule
